// File: rtl/vdp_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vdp_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [2:0]  ALIGN_MASK = 3'b111;
  // VALU function select that routes the S operand straight to Y.
  localparam logic [4:0]  FS_PASS_S  = 5'h04;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LD_LO  = 4'd1,
    S_LO_CAP = 4'd2,
    S_LD_HI  = 4'd3,
    S_HI_CAP = 4'd4,
    S_WB     = 4'd5,
    S_ST_RD  = 4'd6,
    S_ST_LO  = 4'd7,
    S_ST_HI  = 4'd8,
    S_DONE   = 4'd9,
    S_ERR    = 4'd10
  } vdp_state_e;

  // True for states that hold a memory request open.
  function automatic logic is_beat(input vdp_state_e s);
    return (s == S_LD_LO) || (s == S_LD_HI) || (s == S_ST_LO) || (s == S_ST_HI);
  endfunction

endpackage

// File: rtl/vdp_wait_timer.sv
// Per-beat wait counter; expired once MAX_WAIT ackless cycles have elapsed.
module vdp_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  // Count ackless cycles, saturating at MAX_WAIT.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/vdp_mem_seq.sv
// 64-bit vector load/store sequencer over a 32-bit memory port.
module vdp_mem_seq
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              op_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        vreg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       vdp_dy,
  output logic              vdp_din_sel,
  output logic              vdp_dout_sel,
  input  logic [31:0]       vdp_d_out,
  output logic [4:0]        vdp_s_addr,
  output logic [4:0]        vdp_d_addr,
  output logic [4:0]        vdp_fs,
  output logic              vdp_d_en,
  output logic              vdp_y_sel
);

  vdp_state_e        state, state_next;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        vreg_q;
  logic [31:0]       hold_q;
  logic              expired;
  logic              accept;
  logic [ADDR_W-1:0] base_hi;

  assign accept  = (state == S_IDLE) && start;
  assign base_hi = base_q + ADDR_W'(WORD_BYTES);

  // Wait timer restarts on every state change, counts while a beat is unacked.
  vdp_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (state_next != state),
    .en      (is_beat(state) && !mem_ack),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transfer parameters latched on accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      base_q <= '0;
      vreg_q <= '0;
    end else if (accept) begin
      base_q <= base_addr;
      vreg_q <= vreg;
    end
  end

  // Load data hold register, captured on each read ack.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_q <= '0;
    end else if ((state == S_LD_LO || state == S_LD_HI) && mem_ack && !expired) begin
      hold_q <= mem_rdata;
    end
  end

  // Next-state logic; timeout wins over a same-cycle ack.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((base_addr[2:0] & ALIGN_MASK) != 3'b000) state_next = S_ERR;
          else if (op_store)                           state_next = S_ST_RD;
          else                                         state_next = S_LD_LO;
        end
      end
      S_LD_LO:  if (expired) state_next = S_ERR; else if (mem_ack) state_next = S_LO_CAP;
      S_LO_CAP: state_next = S_LD_HI;
      S_LD_HI:  if (expired) state_next = S_ERR; else if (mem_ack) state_next = S_HI_CAP;
      S_HI_CAP: state_next = S_WB;
      S_WB:     state_next = S_IDLE;
      S_ST_RD:  state_next = S_ST_LO;
      S_ST_LO:  if (expired) state_next = S_ERR; else if (mem_ack) state_next = S_ST_HI;
      S_ST_HI:  if (expired) state_next = S_ERR; else if (mem_ack) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode of the registered state.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    vdp_dy       = hold_q;
    vdp_din_sel  = 1'b1;
    vdp_dout_sel = 1'b0;
    vdp_s_addr   = vreg_q;
    vdp_d_addr   = vreg_q;
    vdp_fs       = FS_PASS_S;
    vdp_d_en     = 1'b0;
    vdp_y_sel    = 1'b0;
    case (state)
      S_LD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = base_q;
      end
      S_LO_CAP: vdp_din_sel = 1'b0;
      S_LD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = base_hi;
      end
      S_WB: begin
        vdp_d_en  = 1'b1;
        vdp_y_sel = 1'b1;
        done      = 1'b1;
      end
      S_ST_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = base_q;
        mem_wdata = vdp_d_out;
      end
      S_ST_HI: begin
        mem_wr       = 1'b1;
        mem_addr     = base_hi;
        vdp_dout_sel = 1'b1;
        mem_wdata    = vdp_d_out;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vdp_mem_seq.sv
// Directed bench for vdp_mem_seq with a small memory and datapath model.
module tb_vdp_mem_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        op_store;
  logic [31:0] base_addr;
  logic [4:0]  vreg;
  logic        busy, done, err;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] vdp_dy;
  logic        vdp_din_sel, vdp_dout_sel;
  logic [31:0] vdp_d_out;
  logic [4:0]  vdp_s_addr, vdp_d_addr, vdp_fs;
  logic        vdp_d_en, vdp_y_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  vdp_mem_seq #(.ADDR_W(32), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op_store(op_store),
    .base_addr(base_addr), .vreg(vreg), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .vdp_dy(vdp_dy),
    .vdp_din_sel(vdp_din_sel), .vdp_dout_sel(vdp_dout_sel), .vdp_d_out(vdp_d_out),
    .vdp_s_addr(vdp_s_addr), .vdp_d_addr(vdp_d_addr), .vdp_fs(vdp_fs),
    .vdp_d_en(vdp_d_en), .vdp_y_sel(vdp_y_sel)
  );

  // Memory model: configurable ack latency, one address that never acks.
  logic [31:0] rd_words [16];
  logic [31:0] wr_words [16];
  int          lat = 0;
  int          wait_cnt;
  logic [31:0] stall_addr = 32'hFFFF_FFF0;
  logic        force_ack = 1'b0;
  logic        req;

  assign req       = mem_rd | mem_wr;
  assign mem_rdata = rd_words[mem_addr[5:2]];

  always_comb mem_ack = force_ack | (req && (mem_addr != stall_addr) && (wait_cnt >= lat));

  always @(posedge CLK) begin
    if (!req || mem_ack) wait_cnt <= 0;
    else                 wait_cnt <= wait_cnt + 1;
    if (mem_wr && mem_ack) wr_words[mem_addr[5:2]] <= mem_wdata;
  end

  // Datapath model: HI/LO input buffers, register file, pass-S Y register.
  logic [63:0] rf [32];
  logic [31:0] lo_buf = '0, hi_buf = '0;
  logic [63:0] y_reg = '0;
  logic        rf_pre_we = 1'b0;
  logic [4:0]  rf_pre_addr = '0;
  logic [63:0] rf_pre_data = '0;

  assign vdp_d_out = vdp_dout_sel ? y_reg[63:32] : y_reg[31:0];

  always @(posedge CLK) begin
    if (vdp_din_sel) hi_buf <= vdp_dy;
    else             lo_buf <= vdp_dy;
    if (rf_pre_we)                  rf[rf_pre_addr] <= rf_pre_data;
    else if (vdp_d_en && vdp_y_sel) rf[vdp_d_addr]  <= {hi_buf, lo_buf};
    if (vdp_fs == 5'h04) y_reg <= rf[vdp_s_addr];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},     64'(busy), 64'd0);
    check({tag, ".done"},     64'(done), 64'd0);
    check({tag, ".err"},      64'(err), 64'd0);
    check({tag, ".mem_rd"},   64'(mem_rd), 64'd0);
    check({tag, ".mem_wr"},   64'(mem_wr), 64'd0);
    check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, ".wdata"},    64'(mem_wdata), 64'd0);
    check({tag, ".d_en"},     64'(vdp_d_en), 64'd0);
    check({tag, ".y_sel"},    64'(vdp_y_sel), 64'd0);
    check({tag, ".din_sel"},  64'(vdp_din_sel), 64'd1);
    check({tag, ".dout_sel"}, 64'(vdp_dout_sel), 64'd0);
    check({tag, ".fs"},       64'(vdp_fs), 64'h04);
  endtask

  task automatic issue(input logic st, input logic [31:0] ba, input logic [4:0] vr);
    start = 1'b1; op_store = st; base_addr = ba; vreg = vr;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int done_cnt, err_cnt, rd_cnt, err_cyc, done_cyc;
    logic den_seen, found;

    RESET = 1'b1; start = 1'b0; op_store = 1'b0; base_addr = '0; vreg = '0;
    for (int i = 0; i < 16; i++) rd_words[i] = '0;
    tick(); tick();
    check_idle("reset");
    RESET = 1'b0;

    // Load 0x100 -> vreg 7, zero-wait acks.
    rd_words[0] = 32'h1111_2222; rd_words[1] = 32'h3333_4444; lat = 0;
    issue(1'b0, 32'h100, 5'd7);
    check("ld.c1.rd",   64'(mem_rd), 64'd1);
    check("ld.c1.addr", 64'(mem_addr), 64'h100);
    check("ld.c1.busy", 64'(busy), 64'd1);
    tick();
    check("ld.c2.rd",   64'(mem_rd), 64'd0);
    check("ld.c2.din",  64'(vdp_din_sel), 64'd0);
    check("ld.c2.dy",   64'(vdp_dy), 64'h1111_2222);
    tick();
    check("ld.c3.rd",   64'(mem_rd), 64'd1);
    check("ld.c3.addr", 64'(mem_addr), 64'h104);
    check("ld.c3.din",  64'(vdp_din_sel), 64'd1);
    tick();
    check("ld.c4.rd",   64'(mem_rd), 64'd0);
    check("ld.c4.done", 64'(done), 64'd0);
    tick();
    check("ld.c5.d_en",  64'(vdp_d_en), 64'd1);
    check("ld.c5.y_sel", 64'(vdp_y_sel), 64'd1);
    check("ld.c5.done",  64'(done), 64'd1);
    check("ld.c5.daddr", 64'(vdp_d_addr), 64'd7);
    tick();
    check("ld.c6.done", 64'(done), 64'd0);
    check("ld.c6.busy", 64'(busy), 64'd0);
    check("ld.rf7",     rf[7], 64'h3333_4444_1111_2222);

    // Store vreg 3 -> 0x208, 2-cycle ack latency.
    rf_pre_we = 1'b1; rf_pre_addr = 5'd3; rf_pre_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    rf_pre_we = 1'b0;
    lat = 2; done_cnt = 0;
    issue(1'b1, 32'h208, 5'd3);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      done_cnt += int'(done);
      case (cyc)
        1: check("st.c1.wr", 64'(mem_wr), 64'd0);
        2, 3, 4: begin
          check($sformatf("st.c%0d.wr", cyc),    64'(mem_wr), 64'd1);
          check($sformatf("st.c%0d.addr", cyc),  64'(mem_addr), 64'h208);
          check($sformatf("st.c%0d.wdata", cyc), 64'(mem_wdata), 64'hCCCC_DDDD);
        end
        5, 6, 7: begin
          check($sformatf("st.c%0d.wr", cyc),    64'(mem_wr), 64'd1);
          check($sformatf("st.c%0d.addr", cyc),  64'(mem_addr), 64'h20C);
          check($sformatf("st.c%0d.wdata", cyc), 64'(mem_wdata), 64'hAAAA_BBBB);
        end
        8: begin
          check("st.c8.done", 64'(done), 64'd1);
          check("st.c8.wr",   64'(mem_wr), 64'd0);
        end
        default: check("st.c9.busy", 64'(busy), 64'd0);
      endcase
      if (cyc < 9) tick();
    end
    check("st.done_cnt", 64'(done_cnt), 64'd1);
    check("st.mem_lo",   64'(wr_words[2]), 64'hCCCC_DDDD);
    check("st.mem_hi",   64'(wr_words[3]), 64'hAAAA_BBBB);

    // Misaligned start.
    lat = 0;
    issue(1'b0, 32'h104, 5'd1);
    check("mis.err",  64'(err), 64'd1);
    check("mis.busy", 64'(busy), 64'd1);
    check("mis.rdwr", 64'(mem_rd | mem_wr), 64'd0);
    tick();
    check("mis.err2",  64'(err), 64'd0);
    check("mis.busy2", 64'(busy), 64'd0);

    // Second load beat never acked -> timeout.
    stall_addr = 32'h304; rd_cnt = 0; err_cyc = 0; den_seen = 1'b0;
    issue(1'b0, 32'h300, 5'd5);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      rd_cnt += int'(mem_rd);
      if (vdp_d_en) den_seen = 1'b1;
      if (err && err_cyc == 0) err_cyc = cyc;
      if (cyc < 30) tick();
    end
    check("to.err_cyc", 64'(err_cyc), 64'd19);
    check("to.rd_cnt",  64'(rd_cnt), 64'd17);
    check("to.d_en",    64'(den_seen), 64'd0);
    check("to.busy",    64'(busy), 64'd0);
    stall_addr = 32'hFFFF_FFF0;

    // RESET while in LD_HI, then an immediate new load.
    lat = 3; found = 1'b0;
    issue(1'b0, 32'h100, 5'd9);
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_rd && mem_addr == 32'h104) found = 1'b1;
      else tick();
    end
    check("rst.reach_ld_hi", 64'(found), 64'd1);
    RESET = 1'b1;
    tick();
    check_idle("rst_mid");
    RESET = 1'b0; lat = 0;
    issue(1'b0, 32'h100, 5'd10);
    for (int i = 0; i < 4; i++) tick();
    check("rst.c5.done", 64'(done), 64'd1);
    tick();
    check("rst.rf10", rf[10], 64'h3333_4444_1111_2222);
    check("rst.rf9",  64'(rf[9] === 64'h3333_4444_1111_2222), 64'd0);

    // Stray ack in IDLE and start while busy.
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("stray.busy", 64'(busy), 64'd0);
    rd_words[0] = 32'h5555_6666; rd_words[1] = 32'h7777_8888; lat = 1;
    done_cnt = 0; err_cnt = 0; done_cyc = 0;
    issue(1'b0, 32'h100, 5'd12);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin start = 1'b1; op_store = 1'b1; base_addr = 32'h104; end
      else start = 1'b0;
      done_cnt += int'(done);
      err_cnt  += int'(err);
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc < 10) tick();
    end
    start = 1'b0;
    check("busy_start.done_cyc", 64'(done_cyc), 64'd7);
    check("busy_start.done_cnt", 64'(done_cnt), 64'd1);
    check("busy_start.err_cnt",  64'(err_cnt), 64'd0);
    check("busy_start.rf12",     rf[12], 64'h7777_8888_5555_6666);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
